// File: rtl/hd44780_lcd_driver.sv
// hd44780_lcd_driver
//   Write-only HD44780 character-LCD controller on an 8-bit bus. After reset it
//   waits for the panel to power up, sends a fixed init sequence and then keeps
//   rewriting line 1, columns 0-1 with dataIn as two upper-case hex digits.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   dataIn   in   [7:0] byte to display (sampled once per refresh, at the address write)
//   dataOut  out  [7:0] LCD DB7..DB0
//   en       out  LCD E strobe
//   RW       out  LCD R/W, always 0
//   RS       out  LCD RS (0 = command, 1 = data)
//   BLON     out  backlight enable, 1 whenever out of reset
//   LEDs     out  [7:0] debug LEDs
//
// Build option
//   LCD_STATE_LEDS_EN : LEDs = {state code[2:0], en, snap[3:0]} instead of snap.
//
// Every output is registered. A bus write is SETUP (1 clock, en=0), EN
// (EN_HIGH_CYCLES clocks, en=1), then WAIT (CMD_WAIT_CYCLES clocks, or
// CLR_WAIT_CYCLES after the clear command). dataOut/RS only change when a new
// write is loaded, so they stay stable through the whole write.

module hd44780_lcd_driver #(
    parameter int unsigned POWERUP_CYCLES  = 750000,
    parameter int unsigned EN_HIGH_CYCLES  = 16,
    parameter int unsigned CMD_WAIT_CYCLES = 2000,
    parameter int unsigned CLR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    output logic       en,
    output logic       RW,
    output logic       RS,
    output logic       BLON,
    output logic [7:0] LEDs
);

    // One shared counter serves every wait, so size it for the longest one.
    localparam int unsigned MAX_AB = (POWERUP_CYCLES > EN_HIGH_CYCLES) ? POWERUP_CYCLES : EN_HIGH_CYCLES;
    localparam int unsigned MAX_CD = (CMD_WAIT_CYCLES > CLR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLR_WAIT_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LAST      = CNT_W'(EN_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST     = CNT_W'(CLR_WAIT_CYCLES - 1);

    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_ADDR    = 3'd2,
        ST_HI      = 3'd3,
        ST_LO      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EN    = 2'd1,
        PH_WAIT  = 2'd2
    } phase_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            2'd1:    cmd = 8'h0C;  // display on, cursor off
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = 8'h06;  // entry mode: increment, no shift
        endcase
        return cmd;
    endfunction

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       snap_q, snap_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             blon_q, blon_d;
    logic [7:0]       leds_q, leds_d;

    logic             write_done;
    logic             enter_addr;
    logic [CNT_W-1:0] wait_last;

    // The clear command needs the long post-write wait.
    assign wait_last = (!rs_q && (data_q == CMD_CLEAR)) ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        data_d     = data_q;
        rs_d       = rs_q;
        en_d       = en_q;
        blon_d     = 1'b1;
        write_done = 1'b0;
        enter_addr = 1'b0;

        if (state_q == ST_POWERUP) begin
            if (cnt_q == POWERUP_LAST) begin
                state_d = ST_INIT;
                phase_d = PH_SETUP;
                cnt_d   = '0;
                idx_d   = '0;
                data_d  = init_cmd(2'd0);
                rs_d    = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    en_d    = 1'b1;
                    phase_d = PH_EN;
                    cnt_d   = '0;
                end
                PH_EN: begin
                    if (cnt_q == EN_LAST) begin
                        en_d    = 1'b0;
                        phase_d = PH_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_WAIT: begin
                    if (cnt_q == wait_last) begin
                        write_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    en_d    = 1'b0;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                end
            endcase
        end

        // Completing a write loads the next one straight into SETUP.
        if (write_done) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            case (state_q)
                ST_INIT: begin
                    if (idx_q == 2'd3) begin
                        enter_addr = 1'b1;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        data_d = init_cmd(idx_q + 2'd1);
                        rs_d   = 1'b0;
                    end
                end
                ST_ADDR: begin
                    state_d = ST_HI;
                    data_d  = hex_ascii(snap_q[7:4]);
                    rs_d    = 1'b1;
                end
                ST_HI: begin
                    state_d = ST_LO;
                    data_d  = hex_ascii(snap_q[3:0]);
                    rs_d    = 1'b1;
                end
                ST_LO: begin
                    enter_addr = 1'b1;
                end
                default: begin
                    state_d = ST_POWERUP;
                    cnt_d   = '0;
                end
            endcase
        end

        // Sampling dataIn only here keeps the two digits of one refresh consistent.
        if (enter_addr) begin
            state_d = ST_ADDR;
            data_d  = CMD_SET_DDRAM;
            rs_d    = 1'b0;
            snap_d  = dataIn;
        end

`ifdef LCD_STATE_LEDS_EN
        leds_d = {state_d, en_d, snap_d[3:0]};
`else
        leds_d = snap_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_POWERUP;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            blon_q  <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            blon_q  <= blon_d;
            leds_q  <= leds_d;
        end
    end

    assign dataOut = data_q;
    assign en      = en_q;
    assign RW      = 1'b0;
    assign RS      = rs_q;
    assign BLON    = blon_q;
    assign LEDs    = leds_q;

endmodule

// File: tb/tb_hd44780_lcd_driver.sv
// tb_hd44780_lcd_driver
//   Scoreboard bench for hd44780_lcd_driver with short timing parameters.
//   Expected bus writes are queued by each scenario; a monitor captures every
//   completed en pulse and the scenario pops and compares both.

module tb_hd44780_lcd_driver;

    localparam int unsigned P_POWERUP = 20;
    localparam int unsigned P_EN_HIGH = 2;
    localparam int unsigned P_CMD     = 4;
    localparam int unsigned P_CLR     = 8;
    localparam int          GAP_CMD   = 1 + P_EN_HIGH + P_CMD;
    localparam int          GAP_CLR   = 1 + P_EN_HIGH + P_CLR;

    logic       clk;
    logic       rst;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       en;
    logic       RW;
    logic       RS;
    logic       BLON;
    logic [7:0] LEDs;

    hd44780_lcd_driver #(
        .POWERUP_CYCLES (P_POWERUP),
        .EN_HIGH_CYCLES (P_EN_HIGH),
        .CMD_WAIT_CYCLES(P_CMD),
        .CLR_WAIT_CYCLES(P_CLR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .dataIn (dataIn),
        .dataOut(dataOut),
        .en     (en),
        .RW     (RW),
        .RS     (RS),
        .BLON   (BLON),
        .LEDs   (LEDs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         gap;
        logic [7:0] leds;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       rs;
        logic [7:0] leds;
        logic       blon;
        logic       rw;
        logic [7:0] data_fall;
        logic       rs_fall;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rise;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture each write at en rise; publish it at en fall with the bus value then.
    logic en_prev = 1'b0;
    obs_t cur;
    always @(negedge clk) begin
        if (!rst && en && !en_prev) begin
            cur.cyc  = cyc;
            cur.data = dataOut;
            cur.rs   = RS;
            cur.leds = LEDs;
            cur.blon = BLON;
            cur.rw   = RW;
        end
        if (!rst && !en && en_prev) begin
            cur.data_fall = dataOut;
            cur.rs_fall   = RS;
            obs_q.push_back(cur);
        end
        en_prev = en;
    end

    function automatic logic [7:0] ascii_of(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] exp_leds(input logic [2:0] st, input logic [7:0] snap);
`ifdef LCD_STATE_LEDS_EN
        return {st, 1'b1, snap[3:0]};
`else
        return (st == 3'd7) ? 8'h00 : snap;
`endif
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic r, input int g, input logic [7:0] l);
        exp_t e;
        e.data = d; e.rs = r; e.gap = g; e.leds = l;
        exp_q.push_back(e);
    endtask

    task automatic push_refresh(input logic [7:0] snap);
        push_exp(8'h80, 1'b0, GAP_CMD, exp_leds(3'd2, snap));
        push_exp(ascii_of(snap[7:4]), 1'b1, GAP_CMD, exp_leds(3'd3, snap));
        push_exp(ascii_of(snap[3:0]), 1'b1, GAP_CMD, exp_leds(3'd4, snap));
    endtask

    task automatic get_write(output obs_t o, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        o  = '{default: '0};
        while (obs_q.size() == 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (obs_q.size() > 0) begin
            o  = obs_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        last_rise = cyc;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        dataIn = 8'h00;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({dataOut, en, RW, RS, BLON, LEDs} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got dataOut=%02h en=%0b RW=%0b RS=%0b BLON=%0b LEDs=%02h, required all 0",
                         dataOut, en, RW, RS, BLON, LEDs);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_no_pulse: got %0d en pulses, required 0", obs_q.size());
        end
    endtask

    task automatic test_init();
        exp_t e;
        obs_t o;
        bit   ok;
        release_reset();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({BLON, en} !== 2'b10) begin
            failures++;
            $display("FAIL blon_first_clock: got BLON=%0b en=%0b, required BLON=1 en=0", BLON, en);
        end
        push_exp(8'h38, 1'b0, P_POWERUP + 1, exp_leds(3'd1, 8'h00));
        push_exp(8'h0C, 1'b0, GAP_CMD, exp_leds(3'd1, 8'h00));
        push_exp(8'h01, 1'b0, GAP_CMD, exp_leds(3'd1, 8'h00));
        push_exp(8'h06, 1'b0, GAP_CLR, exp_leds(3'd1, 8'h00));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_write(o, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL init_timeout: got no write, required data=%02h", e.data);
            end else begin
                if ({o.rs, o.data} !== {e.rs, e.data}) begin
                    failures++;
                    $display("FAIL init_data: got rs=%0b data=%02h, required rs=%0b data=%02h", o.rs, o.data, e.rs, e.data);
                end
                checks++;
                if (o.cyc - last_rise !== e.gap) begin
                    failures++;
                    $display("FAIL init_timing: got %0d clocks, required %0d (data=%02h)", o.cyc - last_rise, e.gap, e.data);
                end
                checks++;
                if (o.leds !== e.leds) begin
                    failures++;
                    $display("FAIL init_leds: got %02h, required %02h", o.leds, e.leds);
                end
                checks++;
                if ({o.rs_fall, o.data_fall, o.blon, o.rw} !== {e.rs, e.data, 2'b10}) begin
                    failures++;
                    $display("FAIL init_hold: got rs=%0b data=%02h BLON=%0b RW=%0b at en fall, required rs=%0b data=%02h BLON=1 RW=0",
                             o.rs_fall, o.data_fall, o.blon, o.rw, e.rs, e.data);
                end
                last_rise = o.cyc;
            end
        end
    endtask

    // Shared drain loop body for the refresh scenarios (n writes, inline checks).
    task automatic test_refresh(input string name, input int n);
        exp_t e;
        obs_t o;
        bit   ok;
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            get_write(o, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s_timeout: got no write, required data=%02h", name, e.data);
            end else begin
                if ({o.rs, o.data} !== {e.rs, e.data}) begin
                    failures++;
                    $display("FAIL %s_data: got rs=%0b data=%02h, required rs=%0b data=%02h", name, o.rs, o.data, e.rs, e.data);
                end
                checks++;
                if (o.cyc - last_rise !== e.gap) begin
                    failures++;
                    $display("FAIL %s_timing: got %0d clocks, required %0d", name, o.cyc - last_rise, e.gap);
                end
                checks++;
                if (o.leds !== e.leds) begin
                    failures++;
                    $display("FAIL %s_leds: got %02h, required %02h", name, o.leds, e.leds);
                end
                checks++;
                if ({o.rs_fall, o.data_fall, o.blon, o.rw} !== {e.rs, e.data, 2'b10}) begin
                    failures++;
                    $display("FAIL %s_hold: got rs=%0b data=%02h BLON=%0b RW=%0b at en fall, required rs=%0b data=%02h BLON=1 RW=0",
                             name, o.rs_fall, o.data_fall, o.blon, o.rw, e.rs, e.data);
                end
                last_rise = o.cyc;
            end
        end
    endtask

    task automatic test_refresh_zero();
        push_refresh(8'h00);
        push_refresh(8'h00);
        test_refresh("zero", 6);
    endtask

    task automatic test_hex_a7();
        // Last write popped was a LO write still in its wait: next ADDR sees 0xA7.
        dataIn = 8'hA7;
        push_refresh(8'hA7);
        test_refresh("hex_a7", 3);
    endtask

    task automatic test_mid_change();
        dataIn = 8'h3C;
        push_refresh(8'h3C);
        test_refresh("mid_addr_hi", 2);
        // Between the HI and LO writes: LO must still show the old low nibble.
        dataIn = 8'hF0;
        test_refresh("mid_lo", 1);
        push_refresh(8'hF0);
        test_refresh("mid_next", 3);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (en !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_wait: got en=%0b, required en=1 within 100 clocks", en);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({dataOut, en, RS, BLON, LEDs} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: got dataOut=%02h en=%0b RS=%0b BLON=%0b LEDs=%02h, required all 0",
                     dataOut, en, RS, BLON, LEDs);
        end
        repeat (5) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        release_reset();
        push_exp(8'h38, 1'b0, P_POWERUP + 1, exp_leds(3'd1, 8'h00));
        push_exp(8'h0C, 1'b0, GAP_CMD, exp_leds(3'd1, 8'h00));
        test_refresh("reset_mid_restart", 2);
    endtask

    initial begin
        rst    = 1'b1;
        dataIn = 8'h00;
        test_reset();
        test_init();
        test_refresh_zero();
        test_hex_a7();
        test_mid_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
